// File: rtl/wheel_speed_estimator.sv
// Per-wheel signed speed from free-running 10-bit encoder counts.
// Ports: clk, reset (sync, active-low), enable, r_count/l_count in;
//        r_speed/l_speed (10+AVG_LOG2, signed), speed_valid, sample_err out.
module wheel_speed_estimator #(
    parameter int SAMPLE_CYCLES = 500000,
    parameter int AVG_LOG2      = 2,
    parameter int MAX_TRIES     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [9:0]            r_count,
    input  logic [9:0]            l_count,
    output logic [10+AVG_LOG2-1:0] r_speed,
    output logic [10+AVG_LOG2-1:0] l_speed,
    output logic                  speed_valid,
    output logic                  sample_err
);

    localparam int W     = 10 + AVG_LOG2;
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int PW    = $clog2(SAMPLE_CYCLES);
    localparam int TW    = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        WAIT,
        CAP_A,
        CAP_B,
        COMPUTE,
        ERR
    } state_t;

    state_t         state;
    logic [PW-1:0]  prescaler;
    logic [TW-1:0]  tries;
    logic           primed;
    logic           tick;

    logic [9:0]     r_a, l_a, r_b, l_b;
    logic [9:0]     r_prev, l_prev;
    logic [9:0]     r_hist [DEPTH];
    logic [9:0]     l_hist [DEPTH];

    logic [9:0]     r_delta, l_delta;
    logic [W-1:0]   r_sum_nxt, l_sum_nxt;

    function automatic logic [W-1:0] sext(input logic [9:0] v);
        return {{AVG_LOG2{v[9]}}, v};
    endfunction

    assign tick = (prescaler == PW'(SAMPLE_CYCLES - 1));

    // Modular subtraction handles encoder wrap; the 10-bit result
    // is read as two's complement.
    assign r_delta = r_b - r_prev;
    assign l_delta = l_b - l_prev;

    // The speed outputs double as the running sums: both only ever
    // change together, in COMPUTE, and both clear on reset.
    assign r_sum_nxt = r_speed + sext(r_delta) - sext(r_hist[DEPTH-1]);
    assign l_sum_nxt = l_speed + sext(l_delta) - sext(l_hist[DEPTH-1]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= WAIT;
            prescaler   <= '0;
            tries       <= '0;
            primed      <= 1'b0;
            r_a         <= '0;
            l_a         <= '0;
            r_b         <= '0;
            l_b         <= '0;
            r_prev      <= '0;
            l_prev      <= '0;
            r_speed     <= '0;
            l_speed     <= '0;
            speed_valid <= 1'b0;
            sample_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
                l_hist[i] <= '0;
            end
        end else begin
            speed_valid <= 1'b0;
            sample_err  <= 1'b0;
            if (!enable) begin
                prescaler <= '0;
                state     <= WAIT;
                primed    <= 1'b0;
                tries     <= '0;
            end else begin
                prescaler <= tick ? '0 : prescaler + PW'(1);
                unique case (state)
                    WAIT: begin
                        if (tick) begin
                            r_a   <= r_count;
                            l_a   <= l_count;
                            tries <= tries + TW'(1);
                            state <= CAP_A;
                        end
                    end
                    CAP_A: begin
                        r_b   <= r_count;
                        l_b   <= l_count;
                        state <= CAP_B;
                    end
                    CAP_B: begin
                        // Two equal back-to-back reads mean the async
                        // counter was not mid-update when sampled.
                        if (r_a == r_b && l_a == l_b) begin
                            state <= COMPUTE;
                        end else if (tries < TW'(MAX_TRIES)) begin
                            r_a   <= r_count;
                            l_a   <= l_count;
                            tries <= tries + TW'(1);
                            state <= CAP_A;
                        end else begin
                            sample_err <= 1'b1;
                            state      <= ERR;
                        end
                    end
                    ERR: begin
                        tries <= '0;
                        state <= WAIT;
                    end
                    COMPUTE: begin
                        tries  <= '0;
                        state  <= WAIT;
                        r_prev <= r_b;
                        l_prev <= l_b;
                        if (!primed) begin
                            primed <= 1'b1;
                        end else begin
                            r_hist[0] <= r_delta;
                            l_hist[0] <= l_delta;
                            for (int i = 1; i < DEPTH; i++) begin
                                r_hist[i] <= r_hist[i-1];
                                l_hist[i] <= l_hist[i-1];
                            end
                            r_speed     <= r_sum_nxt;
                            l_speed     <= l_sum_nxt;
                            speed_valid <= 1'b1;
                        end
                    end
                    default: state <= WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wheel_speed_estimator.sv
// Directed bench for wheel_speed_estimator (20-cycle windows).
module tb_wheel_speed_estimator;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [9:0]  r_count;
    logic [9:0]  l_count;
    logic [11:0] r_speed;
    logic [11:0] l_speed;
    logic        speed_valid;
    logic        sample_err;

    int checks   = 0;
    int failures = 0;

    wheel_speed_estimator #(
        .SAMPLE_CYCLES(20),
        .AVG_LOG2(2),
        .MAX_TRIES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .r_count(r_count),
        .l_count(l_count),
        .r_speed(r_speed),
        .l_speed(l_speed),
        .speed_valid(speed_valid),
        .sample_err(sample_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Release reset with enable high; the first tick edge then falls
    // 10 edges after the returned negedge (window phase origin).
    task automatic start();
        reset  = 1'b1;
        enable = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        int pulses = 0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r_count = r_count + 10'd3;
            if (speed_valid || sample_err) pulses++;
        end
        check({tag, "_pulses"}, pulses, 0);
        check({tag, "_r"}, r_speed, 0);
        check({tag, "_l"}, l_speed, 0);
    endtask

    // One 20-cycle window: A captured at edge 10, B at edge 11.
    // r2/l2 are applied between edges 10 and 11 (retry case);
    // unstable makes l_count move every cycle.
    task automatic window(input string tag,
                          input logic [9:0] r, input logic [9:0] l,
                          input logic [9:0] r2, input logic [9:0] l2,
                          input bit unstable, input int vpos, input int epos,
                          input logic [11:0] er, input logic [11:0] el);
        int vcnt = 0, ecnt = 0, vat = 0, eat = 0;
        r_count = r;
        l_count = l;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (speed_valid) begin vcnt++; vat = i; end
            if (sample_err) begin ecnt++; eat = i; end
            if (speed_valid && sample_err) check({tag, "_both"}, 1, 0);
            if (unstable) l_count = l_count + 10'd1;
            else if (i == 10) begin
                r_count = r2;
                l_count = l2;
            end
        end
        check({tag, "_vcnt"}, vcnt, (vpos != 0) ? 1 : 0);
        if (vpos != 0) check({tag, "_vat"}, vat, vpos);
        check({tag, "_ecnt"}, ecnt, (epos != 0) ? 1 : 0);
        if (epos != 0) check({tag, "_eat"}, eat, epos);
        check({tag, "_r"}, r_speed, er);
        check({tag, "_l"}, l_speed, el);
    endtask

    initial begin
        int pulses;
        reset   = 1'b0;
        enable  = 1'b1;
        r_count = 10'd0;
        l_count = 10'd0;

        // Reset with counts moving
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r_count = r_count + 10'd7;
            l_count = l_count + 10'd5;
            check("rst_valid", speed_valid, 0);
            check("rst_err", sample_err, 0);
        end
        check("rst_r", r_speed, 0);
        check("rst_l", l_speed, 0);
        start();

        // Ramp: tick edge 10 -> valid visible after edge 13
        window("prime", 0, 100, 0, 100, 0, 0, 0, 0, 0);
        window("ramp1", 10, 100, 10, 100, 0, 13, 0, 10, 0);
        window("ramp2", 20, 100, 20, 100, 0, 13, 0, 20, 0);
        window("ramp3", 30, 100, 30, 100, 0, 13, 0, 30, 0);
        window("ramp4", 40, 100, 40, 100, 0, 13, 0, 40, 0);
        window("ramp5", 50, 100, 50, 100, 0, 13, 0, 40, 0);

        // Unstable l for all three attempts: err after edge 16
        window("unst", 60, 100, 60, 100, 1, 0, 16, 40, 0);
        // Delta spans two windows: r 50->70, l 100->120
        window("post_unst", 70, 120, 70, 120, 0, 13, 0, 50, 20);

        // Retry: B of first attempt differs -> valid after edge 15
        window("retry", 80, 130, 85, 140, 0, 15, 0, 55, 40);

        // Wrap forward
        do_reset("rst2");
        start();
        window("wrap_prime", 1020, 7, 1020, 7, 0, 0, 0, 0, 0);
        window("wrap_fwd", 4, 7, 4, 7, 0, 13, 0, 12'd8, 0);

        // Wrap backward from a fresh history
        do_reset("rst3");
        start();
        window("back_prime", 4, 7, 4, 7, 0, 0, 0, 0, 0);
        window("wrap_back", 1020, 7, 1020, 7, 0, 13, 0, 12'hFF8, 0);

        // Drop enable while in CAP_B
        pulses = 0;
        r_count = 10'd30;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (speed_valid || sample_err) pulses++;
            if (i == 11) enable = 1'b0;
        end
        check("drop_pulses", pulses, 0);
        check("drop_r", r_speed, 12'hFF8);
        check("drop_l", l_speed, 0);
        start();
        window("reen_prime", 40, 7, 40, 7, 0, 0, 0, 12'hFF8, 0);
        window("reen_win", 50, 7, 50, 7, 0, 13, 0, 12'd2, 0);

        // Reset mid-window
        pulses = 0;
        r_count = 10'd55;
        repeat (5) begin
            @(negedge clk);
            if (speed_valid || sample_err) pulses++;
        end
        check("mid_pulses", pulses, 0);
        do_reset("rst4");
        start();
        window("mid_prime", 60, 7, 60, 7, 0, 0, 0, 0, 0);
        window("mid_win", 65, 7, 65, 7, 0, 13, 0, 12'd5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
